// File: rtl/ravenoc_pkt_tx_if.sv
// ravenoc_pkt_tx_if: cmd/payload/flit handshake bundle; master = transmitter, slave = core/router side
interface ravenoc_pkt_tx_if #(
   parameter int FLIT_WIDTH = 34,
   parameter int N_VIRT_CHN = 3,
   parameter int X_W = 2,
   parameter int Y_W = 2,
   parameter int LEN_W = 8
);
   localparam int VC_W = $clog2(N_VIRT_CHN > 2 ? N_VIRT_CHN : 2);
   logic cmd_valid_i;
   logic cmd_ready_o;
   logic [X_W-1:0] cmd_dst_x_i;
   logic [Y_W-1:0] cmd_dst_y_i;
   logic [LEN_W-1:0] cmd_len_i;
   logic [VC_W-1:0] cmd_vc_i;
   logic pld_valid_i;
   logic pld_ready_o;
   logic [FLIT_WIDTH-3:0] pld_data_i;
   logic flit_valid_o;
   logic [FLIT_WIDTH-1:0] flit_data_o;
   logic [VC_W-1:0] flit_vc_o;
   logic [N_VIRT_CHN-1:0] flit_ready_i;
   logic busy_o;
   logic err_o;
   modport master (
      input cmd_valid_i, cmd_dst_x_i, cmd_dst_y_i, cmd_len_i, cmd_vc_i, pld_valid_i, pld_data_i, flit_ready_i,
      output cmd_ready_o, pld_ready_o, flit_valid_o, flit_data_o, flit_vc_o, busy_o, err_o
   );
   modport slave (
      output cmd_valid_i, cmd_dst_x_i, cmd_dst_y_i, cmd_len_i, cmd_vc_i, pld_valid_i, pld_data_i, flit_ready_i,
      input cmd_ready_o, pld_ready_o, flit_valid_o, flit_data_o, flit_vc_o, busy_o, err_o
   );
endinterface

// File: rtl/ravenoc_pkt_tx.sv
// ravenoc_pkt_tx: NI transmitter; clk/arst plus bus (cmd, payload in; head/body/tail flits out per VC; busy, err)
module ravenoc_pkt_tx #(
   parameter int FLIT_WIDTH = 34,
   parameter int N_VIRT_CHN = 3,
   parameter int NOC_SZ_X = 2,
   parameter int NOC_SZ_Y = 2,
   parameter int X_W = 2,
   parameter int Y_W = 2,
   parameter int LEN_W = 8,
   parameter int SRC_X = 0,
   parameter int SRC_Y = 0
) (
   input logic clk,
   input logic arst,
   ravenoc_pkt_tx_if.master bus
);
   localparam int VC_W = $clog2(N_VIRT_CHN > 2 ? N_VIRT_CHN : 2);
   localparam int HW = 2*(X_W+Y_W)+LEN_W;
   localparam int PW = FLIT_WIDTH-2;
   if (PW < HW) begin : g_chk
      $error("ravenoc_pkt_tx: head fields do not fit in flit");
   end
   typedef enum logic [1:0] {IDLE, HEAD, BODY, DRAIN} state_t;
   state_t state, state_n;
   logic [VC_W-1:0] vc, vc_n, cvc;
   logic [LEN_W-1:0] rem, rem_n;
   logic fv, fv_n, err, err_n;
   logic [FLIT_WIDTH-1:0] fd, fd_n;
   logic [PW-1:0] head;
   logic bad, xfer, cmd_acc, pld_acc;
   assign xfer = fv & bus.flit_ready_i[vc];
   assign bad = ({1'b0, bus.cmd_dst_x_i} >= (X_W+1)'(NOC_SZ_X)) | ({1'b0, bus.cmd_dst_y_i} >= (Y_W+1)'(NOC_SZ_Y));
   assign cvc = ({1'b0, bus.cmd_vc_i} >= (VC_W+1)'(N_VIRT_CHN)) ? '0 : bus.cmd_vc_i;
   assign head = PW'({bus.cmd_dst_x_i, bus.cmd_dst_y_i, X_W'(SRC_X), Y_W'(SRC_Y), bus.cmd_len_i}) << (PW-HW);
   assign bus.cmd_ready_o = state == IDLE;
   assign bus.pld_ready_o = state == DRAIN | (state == BODY & rem != '0 & (!fv | bus.flit_ready_i[vc]));
   assign cmd_acc = bus.cmd_valid_i & bus.cmd_ready_o;
   assign pld_acc = bus.pld_valid_i & bus.pld_ready_o;
   assign bus.flit_valid_o = fv;
   assign bus.flit_data_o = fd;
   assign bus.flit_vc_o = vc;
   assign bus.busy_o = state != IDLE;
   assign bus.err_o = err;
   always_comb begin
      state_n = state;
      vc_n = vc;
      rem_n = rem;
      fv_n = fv;
      fd_n = fd;
      err_n = cmd_acc & bad;
      case (state)
         IDLE: if (cmd_acc) begin
            rem_n = bus.cmd_len_i;
            if (bad) state_n = bus.cmd_len_i != '0 ? DRAIN : IDLE;
            else begin
               state_n = HEAD;
               vc_n = cvc;
               fv_n = 1'b1;
               fd_n = {bus.cmd_len_i == '0 ? 2'b11 : 2'b00, head};
            end
         end
         HEAD: if (xfer) begin
            fv_n = 1'b0;
            state_n = rem == '0 ? IDLE : BODY;
         end
         BODY: begin
            if (xfer) fv_n = 1'b0;
            if (pld_acc) begin
               fv_n = 1'b1;
               rem_n = rem - 1'b1;
               fd_n = {rem == LEN_W'(1) ? 2'b10 : 2'b01, bus.pld_data_i};
            end
            if (xfer && rem == '0) state_n = IDLE;
         end
         DRAIN: if (pld_acc) begin
            rem_n = rem - 1'b1;
            if (rem == LEN_W'(1)) state_n = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk)
      if (arst) begin
         state <= IDLE;
         vc <= '0;
         rem <= '0;
         fv <= 1'b0;
         fd <= '0;
         err <= 1'b0;
      end else begin
         state <= state_n;
         vc <= vc_n;
         rem <= rem_n;
         fv <= fv_n;
         fd <= fd_n;
         err <= err_n;
      end
endmodule
